// File: rtl/word_serializer16_pkg.sv
// Shared types and constants for the 16-bit word serializer.
package word_serializer16_pkg;

  localparam int WORD_W = 16;
  localparam int CNT_W  = 5;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WORD_W - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2
  } state_e;

endpackage

// File: rtl/word_serializer16_if.sv
// Word-in / bit-out bus for word_serializer16 (slave = serializer, master = environment).
interface word_serializer16_if;
  import word_serializer16_pkg::*;

  // A transfer on either side happens on a rising clk edge where valid and
  // ready are both high; a source holds valid and its payload until that edge.
  // in_ready may depend combinationally on ser_ready (zero-bubble next word).
  logic [WORD_W-1:0] in_data;
  logic              in_valid;
  logic              in_ready;
  logic              ser_bit;
  logic              ser_valid;
  logic              ser_ready;
  logic              ser_first;
  logic              ser_last;
  logic              busy;

  modport slave (
    input  in_data, in_valid, ser_ready,
    output in_ready, ser_bit, ser_valid, ser_first, ser_last, busy
  );

  modport master (
    output in_data, in_valid, ser_ready,
    input  in_ready, ser_bit, ser_valid, ser_first, ser_last, busy
  );

endinterface

// File: rtl/word_serializer16.sv
// Serializes one 16-bit word per input handshake into single-bit beats with first/last strobes.
// Define WORD_SERIALIZER16_PARITY_EN to append an even-parity beat to every word.
module word_serializer16
  import word_serializer16_pkg::*;
#(
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic                clk,
  input  logic                rst,
  word_serializer16_if.slave  bus,
  output state_e              dbg_state_o
);

  state_e              state_q, state_d;
  logic [WORD_W-1:0]   shreg_q, shreg_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
`ifdef WORD_SERIALIZER16_PARITY_EN
  logic                parity_q, parity_d;
`endif

  logic last_beat;
  logic beat_acc;
  logic in_ready_c;
  logic load;
  logic bit_c;

  always_comb begin
    state_d  = state_q;
    shreg_d  = shreg_q;
    cnt_d    = cnt_q;
`ifdef WORD_SERIALIZER16_PARITY_EN
    parity_d = parity_q;
    last_beat = (state_q == PARITY);
`else
    last_beat = (state_q == SHIFT) && (cnt_q == LAST_CNT);
`endif
    beat_acc   = (state_q != IDLE) && bus.ser_ready;
    in_ready_c = !rst && ((state_q == IDLE) || (last_beat && bus.ser_ready));
    load       = in_ready_c && bus.in_valid;

    case (state_q)
      IDLE: ;
      SHIFT: begin
        if (beat_acc) begin
          shreg_d = MSB_FIRST ? {shreg_q[WORD_W-2:0], 1'b0} : {1'b0, shreg_q[WORD_W-1:1]};
          cnt_d   = cnt_q + 1'b1;
          if (cnt_q == LAST_CNT) begin
`ifdef WORD_SERIALIZER16_PARITY_EN
            state_d = PARITY;
`else
            state_d = IDLE;
`endif
          end
        end
      end
`ifdef WORD_SERIALIZER16_PARITY_EN
      PARITY: begin
        if (beat_acc) state_d = IDLE;
      end
`endif
      default: state_d = IDLE;
    endcase

    // A load on the last accepted beat overrides the return to IDLE.
    if (load) begin
      shreg_d = bus.in_data;
      cnt_d   = '0;
      state_d = SHIFT;
`ifdef WORD_SERIALIZER16_PARITY_EN
      parity_d = ^bus.in_data;
`endif
    end
  end

  always_comb begin
    bit_c = 1'b0;
    case (state_q)
      SHIFT:   bit_c = MSB_FIRST ? shreg_q[WORD_W-1] : shreg_q[0];
`ifdef WORD_SERIALIZER16_PARITY_EN
      PARITY:  bit_c = parity_q;
`endif
      default: bit_c = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      shreg_q  <= '0;
      cnt_q    <= '0;
`ifdef WORD_SERIALIZER16_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      shreg_q  <= shreg_d;
      cnt_q    <= cnt_d;
`ifdef WORD_SERIALIZER16_PARITY_EN
      parity_q <= parity_d;
`endif
    end
  end

  // Beat outputs are pure functions of registered state, so they hold during stalls.
  assign bus.in_ready  = in_ready_c;
  assign bus.ser_valid = (state_q != IDLE);
  assign bus.ser_bit   = bit_c;
  assign bus.ser_first = (state_q == SHIFT) && (cnt_q == '0);
  assign bus.ser_last  = last_beat;
  assign bus.busy      = (state_q != IDLE);
  assign dbg_state_o   = state_q;

endmodule

// File: tb/tb_word_serializer16.sv
// Directed bench for word_serializer16: one LSB-first and one MSB-first instance on a shared clock.
module tb_word_serializer16;
  import word_serializer16_pkg::*;

`ifdef WORD_SERIALIZER16_PARITY_EN
  localparam int BEATS = 17;
`else
  localparam int BEATS = 16;
`endif

  // clock / reset
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  word_serializer16_if ifa ();
  word_serializer16_if ifb ();
  state_e dbg_a, dbg_b;

  word_serializer16 #(.MSB_FIRST(1'b0)) dut_a (
    .clk(clk), .rst(rst), .bus(ifa), .dbg_state_o(dbg_a)
  );
  word_serializer16 #(.MSB_FIRST(1'b1)) dut_b (
    .clk(clk), .rst(rst), .bus(ifb), .dbg_state_o(dbg_b)
  );

  // scoreboard: {bit, first, last} per beat
  logic [2:0]  exp_q[$];
  logic [2:0]  exp_b_q[$];
  int          n_cmp = 0;
  int          n_err = 0;
  logic [15:0] got_a = '0;
  logic [15:0] got_b = '0;
  int          idx_a = 0;
  int          idx_b = 0;
  int          firsts_a = 0;
  logic        held_v = 1'b0;
  logic [2:0]  held = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [2:0] model_beat(input logic [15:0] w, input bit msb, input int i);
    logic b;
    if (i == 16) return {^w, 1'b0, 1'b1};
    b = msb ? w[15-i] : w[i];
    return {b, (i == 0), (i == BEATS - 1)};
  endfunction

  task automatic push_word(input logic [15:0] w, input bit msb);
    for (int i = 0; i < BEATS; i++) begin
      if (msb) exp_b_q.push_back(model_beat(w, 1'b1, i));
      else     exp_q.push_back(model_beat(w, 1'b0, i));
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle_a(input string tag);
    int n = 0;
    while ((ifa.busy || exp_q.size() != 0) && n < 200) begin
      tick();
      n++;
    end
    check(tag, (n < 200), 1);
  endtask

  task automatic wait_idle_b(input string tag);
    int n = 0;
    while ((ifb.busy || exp_b_q.size() != 0) && n < 200) begin
      tick();
      n++;
    end
    check(tag, (n < 200), 1);
  endtask

  // monitors sample on the falling edge
  always @(negedge clk) begin : mon_a
    logic [2:0] cur;
    cur = {ifa.ser_bit, ifa.ser_first, ifa.ser_last};
    if (held_v && ifa.ser_valid) check("hold_a", cur, held);
    held_v = ifa.ser_valid && !ifa.ser_ready && !rst;
    held   = cur;
    if (ifa.ser_valid && ifa.ser_ready) begin
      if (ifa.ser_first) begin
        idx_a = 0;
        firsts_a++;
      end
      if (idx_a < 16) got_a = {got_a[14:0], ifa.ser_bit};
      idx_a++;
      if (exp_q.size() == 0) check("extra_beat_a", 1, 0);
      else                   check("beat_a", cur, exp_q.pop_front());
    end
  end

  always @(negedge clk) begin : mon_b
    logic [2:0] cur;
    cur = {ifb.ser_bit, ifb.ser_first, ifb.ser_last};
    if (ifb.ser_valid && ifb.ser_ready) begin
      if (ifb.ser_first) idx_b = 0;
      if (idx_b < 16) got_b = {got_b[14:0], ifb.ser_bit};
      idx_b++;
      if (exp_b_q.size() == 0) check("extra_beat_b", 1, 0);
      else                     check("beat_b", cur, exp_b_q.pop_front());
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: observed no finish expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int f0;
    rst           = 1'b1;
    ifa.in_valid  = 1'b1;
    ifa.in_data   = 16'hA5C3;
    ifa.ser_ready = 1'b1;
    ifb.in_valid  = 1'b0;
    ifb.in_data   = '0;
    ifb.ser_ready = 1'b1;

    // reset held 3 cycles with in_valid high
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rst_in_ready", ifa.in_ready, 0);
      check("rst_ser_valid", ifa.ser_valid, 0);
      check("rst_busy", ifa.busy, 0);
    end
    check("rst_state", dbg_a, IDLE);
    check("rst_ser_bit", ifa.ser_bit, 0);

    // LSB-first 16'hA5C3 as the first handshake after reset
    push_word(16'hA5C3, 1'b0);
    rst = 1'b0;
    #1;
    check("idle_in_ready", ifa.in_ready, 1);
    tick();
    ifa.in_valid = 1'b0;
    wait_idle_a("a5c3_done");
    check("a5c3_bits", got_a, 16'hC3A5);
    check("a5c3_beats", idx_a, BEATS);

    // MSB-first 16'h0001
    push_word(16'h0001, 1'b1);
    ifb.in_data  = 16'h0001;
    ifb.in_valid = 1'b1;
    tick();
    ifb.in_valid = 1'b0;
    wait_idle_b("msb_done");
    check("msb_bits", got_b, 16'h0001);
    check("msb_beats", idx_b, BEATS);

    // backpressure: ser_ready alternates, each beat stalled once
    push_word(16'hFFFF, 1'b0);
    ifa.in_data  = 16'hFFFF;
    ifa.in_valid = 1'b1;
    tick();
    ifa.in_valid = 1'b0;
    for (int c = 0; c < 2 * BEATS; c++) begin
      ifa.ser_ready = (c % 2 == 1);
      @(negedge clk);
      check("bp_busy", ifa.busy, 1);
      check("bp_valid", ifa.ser_valid, 1);
      tick();
    end
    ifa.ser_ready = 1'b1;
    check("bp_done_busy", ifa.busy, 0);
    check("bp_drained", exp_q.size(), 0);

    // back-to-back words with in_valid held high
    push_word(16'h1234, 1'b0);
    push_word(16'hFEDC, 1'b0);
    f0 = firsts_a;
    ifa.in_data  = 16'h1234;
    ifa.in_valid = 1'b1;
    for (int c = 0; c <= 2 * BEATS; c++) begin
      @(negedge clk);
      check("b2b_in_ready", ifa.in_ready, (c == 0) || (c == BEATS) || (c == 2 * BEATS));
      if (c > 0) begin
        check("b2b_valid", ifa.ser_valid, 1);
        check("b2b_first", ifa.ser_first, (c == 1) || (c == BEATS + 1));
      end
      tick();
      if (c == 0) ifa.in_data = 16'hFEDC;
      if (c == BEATS) ifa.in_valid = 1'b0;
    end
    check("b2b_done_busy", ifa.busy, 0);
    check("b2b_drained", exp_q.size(), 0);
    check("b2b_firsts", firsts_a - f0, 2);

    // reset while beat 7 of 16'hBEEF is on the wire
    push_word(16'hBEEF, 1'b0);
    ifa.in_data  = 16'hBEEF;
    ifa.in_valid = 1'b1;
    tick();
    ifa.in_valid = 1'b0;
    repeat (7) tick();
    rst = 1'b1;
    tick();
    check("midrst_valid", ifa.ser_valid, 0);
    check("midrst_busy", ifa.busy, 0);
    check("midrst_last", ifa.ser_last, 0);
    exp_q.delete();
    rst = 1'b0;

    push_word(16'h0F0F, 1'b0);
    ifa.in_data  = 16'h0F0F;
    ifa.in_valid = 1'b1;
    tick();
    ifa.in_valid = 1'b0;
    wait_idle_a("0f0f_done");
    check("0f0f_bits", got_a, 16'hF0F0);
    check("0f0f_beats", idx_a, BEATS);

    repeat (2) tick();
    check("final_drain_a", exp_q.size(), 0);
    check("final_drain_b", exp_b_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
